// File: rtl/aq_gemac_tx_arb_if.sv
// rtl/aq_gemac_tx_arb_if.sv - requester, buffer and status signals of the TX buffer write arbiter
interface aq_gemac_tx_arb_if #(
  parameter int EMAC_TX_DEPTH = 10
);
  logic                     a_req_i;
  logic [EMAC_TX_DEPTH-1:0] a_len_i;
  logic                     a_valid_i;
  logic [31:0]              a_data_i;
  logic                     a_ready_o;
  logic                     a_gnt_o;
  logic                     a_done_o;

  logic                     b_req_i;
  logic [EMAC_TX_DEPTH-1:0] b_len_i;
  logic                     b_valid_i;
  logic [31:0]              b_data_i;
  logic                     b_ready_o;
  logic                     b_gnt_o;
  logic                     b_done_o;

  logic                     buff_we_o;
  logic                     buff_start_o;
  logic                     buff_end_o;
  logic [31:0]              buff_data_o;
  logic                     buff_ready_i;
  logic                     buff_full_i;
  logic [EMAC_TX_DEPTH-1:0] buff_space_i;
  logic                     arb_busy_o;

  modport slave (
    input  a_req_i, a_len_i, a_valid_i, a_data_i,
    input  b_req_i, b_len_i, b_valid_i, b_data_i,
    input  buff_ready_i, buff_full_i, buff_space_i,
    output a_ready_o, a_gnt_o, a_done_o,
    output b_ready_o, b_gnt_o, b_done_o,
    output buff_we_o, buff_start_o, buff_end_o, buff_data_o, arb_busy_o
  );

  modport master (
    output a_req_i, a_len_i, a_valid_i, a_data_i,
    output b_req_i, b_len_i, b_valid_i, b_data_i,
    output buff_ready_i, buff_full_i, buff_space_i,
    input  a_ready_o, a_gnt_o, a_done_o,
    input  b_ready_o, b_gnt_o, b_done_o,
    input  buff_we_o, buff_start_o, buff_end_o, buff_data_o, arb_busy_o
  );
endinterface

// File: rtl/aq_gemac_tx_arb.sv
// rtl/aq_gemac_tx_arb.sv - frame-level round-robin arbiter for the two-requester MAC TX buffer write port
module aq_gemac_tx_arb #(
  parameter int EMAC_TX_DEPTH = 10,
  parameter int MARGIN        = 4
) (
  input  logic              buff_clk_i,
  input  logic              rst_n_i,
  aq_gemac_tx_arb_if.slave  bus
);
  localparam int W = EMAC_TX_DEPTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  logic [1:0]  state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] len_q, len_d;
  logic        dcnt_q, dcnt_d;
  logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic        a_done_q, a_done_d, b_done_q, b_done_d;
  logic        we_q, we_d, start_q, start_d, end_q, end_d;
  logic [31:0] data_q, data_d;

  logic         a_elig, b_elig, pick;
  logic [W-1:0] pick_len;
  logic [W:0]   need;
  logic         admit, accept, is_last;
  logic [31:0]  cur_data;

  assign a_elig   = bus.a_req_i && (bus.a_len_i != '0);
  assign b_elig   = bus.b_req_i && (bus.b_len_i != '0);
  // With both eligible the one not served last wins; otherwise the lone eligible one.
  assign pick     = (a_elig && b_elig) ? ~last_q : b_elig;
  assign pick_len = (pick == SEL_B) ? bus.b_len_i : bus.a_len_i;
  assign need     = {1'b0, pick_len} + (W+1)'(MARGIN);
  assign admit    = (a_elig || b_elig) && bus.buff_ready_i && !bus.buff_full_i &&
                    ({1'b0, bus.buff_space_i} >= need);

  assign bus.a_ready_o = a_gnt_q && (state_q == S_XFER) && !bus.buff_full_i;
  assign bus.b_ready_o = b_gnt_q && (state_q == S_XFER) && !bus.buff_full_i;

  assign accept   = (sel_q == SEL_B) ? (bus.b_ready_o && bus.b_valid_i)
                                     : (bus.a_ready_o && bus.a_valid_i);
  assign cur_data = (sel_q == SEL_B) ? bus.b_data_i : bus.a_data_i;
  assign is_last  = (cnt_q == len_q - 1'b1);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    dcnt_d   = dcnt_q;
    a_gnt_d  = a_gnt_q;
    b_gnt_d  = b_gnt_q;
    a_done_d = 1'b0;
    b_done_d = 1'b0;
    we_d     = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    data_d   = data_q;
    case (state_q)
      S_IDLE: begin
        if (admit) begin
          sel_d   = pick;
          last_d  = pick;
          len_d   = pick_len;
          cnt_d   = '0;
          a_gnt_d = (pick == SEL_A);
          b_gnt_d = (pick == SEL_B);
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (accept) begin
          we_d    = 1'b1;
          data_d  = cur_data;
          start_d = (cnt_q == '0);
          end_d   = is_last;
          cnt_d   = cnt_q + 1'b1;
          if (is_last) begin
            a_gnt_d  = 1'b0;
            b_gnt_d  = 1'b0;
            a_done_d = (sel_q == SEL_A);
            b_done_d = (sel_q == SEL_B);
            dcnt_d   = 1'b0;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Two cycles so the buffer can drop READY and refresh SPACE before re-admission.
        if (dcnt_q) state_d = S_IDLE;
        else        dcnt_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge buff_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      sel_q    <= SEL_A;
      last_q   <= SEL_B;
      cnt_q    <= '0;
      len_q    <= '0;
      dcnt_q   <= 1'b0;
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      dcnt_q   <= dcnt_d;
      a_gnt_q  <= a_gnt_d;
      b_gnt_q  <= b_gnt_d;
      a_done_q <= a_done_d;
      b_done_q <= b_done_d;
      we_q     <= we_d;
      start_q  <= start_d;
      end_q    <= end_d;
      data_q   <= data_d;
    end
  end

  assign bus.a_gnt_o      = a_gnt_q;
  assign bus.b_gnt_o      = b_gnt_q;
  assign bus.a_done_o     = a_done_q;
  assign bus.b_done_o     = b_done_q;
  assign bus.buff_we_o    = we_q;
  assign bus.buff_start_o = start_q;
  assign bus.buff_end_o   = end_q;
  assign bus.buff_data_o  = data_q;
  assign bus.arb_busy_o   = (state_q != S_IDLE);
endmodule

// File: tb/tb_aq_gemac_tx_arb.sv
// tb/tb_aq_gemac_tx_arb.sv - directed and randomized self-checking bench for aq_gemac_tx_arb
module tb_aq_gemac_tx_arb;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aq_gemac_tx_arb_if #(.EMAC_TX_DEPTH(W)) bus ();
  aq_gemac_tx_arb #(.EMAC_TX_DEPTH(W), .MARGIN(4)) dut (
    .buff_clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );

  typedef struct { logic [31:0] d; bit s; bit e; bit dn; bit g; int cyc; } wr_t;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit req_c[2], ven[2], auto_m[2], acc[2], rdy_seen[2], prev_gnt[2];
  logic [W-1:0] len_c[2];
  int idx[2], done_n[2];
  logic [31:0] words[2][64];
  bit rnd_valid, rnd_full, full_c, bready_c;
  logic [W-1:0] space_c;
  wr_t wq[$];
  int gq[$];
  int lenlog[2][$];
  logic [31:0] explog[2][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_frame(input int x, input int len);
    len_c[x] = W'(len);
    idx[x] = 0;
    for (int i = 0; i < len; i++) begin
      words[x][i] = $urandom;
      explog[x].push_back(words[x][i]);
    end
    lenlog[x].push_back(len);
    req_c[x] = 1'b1;
  endtask

  task automatic clear_logs();
    wq.delete(); gq.delete();
    for (int x = 0; x < 2; x++) begin
      lenlog[x].delete(); explog[x].delete(); done_n[x] = 0;
    end
  endtask

  // Drive one cycle of stimulus, let the clock edge pass, then observe at the falling edge.
  task automatic step();
    logic v[2];
    for (int x = 0; x < 2; x++)
      v[x] = ven[x] && (idx[x] < int'(len_c[x])) && (!rnd_valid || $urandom_range(0, 3) != 0);
    if (rnd_full) full_c = ($urandom_range(0, 7) == 0);
    bus.a_req_i = req_c[0]; bus.a_len_i = len_c[0]; bus.a_valid_i = v[0];
    bus.a_data_i = words[0][idx[0] % 64];
    bus.b_req_i = req_c[1]; bus.b_len_i = len_c[1]; bus.b_valid_i = v[1];
    bus.b_data_i = words[1][idx[1] % 64];
    bus.buff_ready_i = bready_c; bus.buff_full_i = full_c;
    bus.buff_space_i = full_c ? '0 : space_c;
    #1;
    acc[0] = bus.a_ready_o && v[0]; rdy_seen[0] = bus.a_ready_o;
    acc[1] = bus.b_ready_o && v[1]; rdy_seen[1] = bus.b_ready_o;
    @(negedge clk);
    cyc++;
    if (bus.buff_we_o)
      wq.push_back('{bus.buff_data_o, bus.buff_start_o, bus.buff_end_o,
                     bus.a_done_o || bus.b_done_o, bus.a_gnt_o || bus.b_gnt_o, cyc});
    if (bus.a_gnt_o && !prev_gnt[0]) gq.push_back(0);
    if (bus.b_gnt_o && !prev_gnt[1]) gq.push_back(1);
    prev_gnt[0] = bus.a_gnt_o; prev_gnt[1] = bus.b_gnt_o;
    for (int x = 0; x < 2; x++) begin
      if (acc[x]) idx[x]++;
      if ((x == 0) ? bus.a_done_o : bus.b_done_o) begin
        done_n[x]++;
        if (auto_m[x]) new_frame(x, $urandom_range(1, 8));
        else req_c[x] = 1'b0;
      end
    end
  endtask

  task automatic run_until_done(input int x, input int budget);
    int target = done_n[x] + 1;
    for (int n = 0; n < budget && done_n[x] < target; n++) step();
    if (done_n[x] < target) chk($sformatf("done_timeout%0d", x), done_n[x], target);
  endtask

  task automatic run_until_idx(input int x, input int v, input int budget);
    for (int n = 0; n < budget && idx[x] < v; n++) step();
    if (idx[x] < v) chk("idx_timeout", idx[x], v);
  endtask

  // Expected write stream: whole frames back to back in the given grant order.
  task automatic verify_stream(input string tag, input int order[$]);
    int p = 0;
    int fi[2] = '{0, 0};
    int base[2] = '{0, 0};
    foreach (order[k]) begin
      int x = order[k];
      int len = lenlog[x][fi[x]];
      for (int i = 0; i < len; i++) begin
        if (p >= wq.size()) begin
          chk({tag, "_short"}, wq.size(), p + 1);
          return;
        end
        chk($sformatf("%s_w%0d", tag, p), {wq[p].d, wq[p].s, wq[p].e},
            {explog[x][base[x] + i], i == 0, i == len - 1});
        if (i == 0 && p > 0)
          chk($sformatf("%s_gap%0d", tag, p), (wq[p].cyc - wq[p-1].cyc) >= 4, 1'b1);
        p++;
      end
      base[x] += len;
      fi[x]++;
    end
    chk({tag, "_count"}, wq.size(), p);
  endtask

  task automatic setup_plain();
    for (int x = 0; x < 2; x++) begin
      req_c[x] = 0; ven[x] = 1; auto_m[x] = 0; idx[x] = 0; len_c[x] = '0;
    end
    rnd_valid = 0; rnd_full = 0; full_c = 0; bready_c = 1; space_c = W'(1000);
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.a_gnt_o, bus.b_gnt_o, bus.a_ready_o, bus.b_ready_o, bus.a_done_o,
            bus.b_done_o, bus.buff_we_o, bus.buff_start_o, bus.buff_end_o,
            bus.arb_busy_o, bus.buff_data_o};
  endfunction

  initial begin
    int total;
    bit a_seen;
    setup_plain();
    clear_logs();
    step(); step();
    chk("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    step();

    // Single A frame, LEN=5
    new_frame(0, 5);
    step();
    chk("t1_gnt", {bus.a_gnt_o, bus.b_gnt_o, bus.arb_busy_o}, 3'b101);
    run_until_done(0, 60);
    chk("t1_busy_d0", bus.arb_busy_o, 1'b1);
    step(); chk("t1_busy_d1", bus.arb_busy_o, 1'b1);
    step(); chk("t1_busy_idle", bus.arb_busy_o, 1'b0);
    verify_stream("t1", '{0});
    if (wq.size() == 5) begin
      chk("t1_back2back", wq[4].cyc - wq[0].cyc, 4);
      chk("t1_last_flags", {wq[4].dn, wq[4].g}, 2'b10);
      chk("t1_mid_flags", {wq[0].dn, wq[3].dn}, 2'b00);
    end

    // Randomized round-robin from reset against the frame-order model
    rst_n = 1'b0; step(); rst_n = 1'b1;
    setup_plain(); clear_logs();
    auto_m[0] = 1; auto_m[1] = 1; rnd_valid = 1; rnd_full = 1;
    new_frame(0, 3); new_frame(1, 3);
    for (int n = 0; n < 4000 && (done_n[0] + done_n[1]) < 12; n++) step();
    chk("rr_progress", (done_n[0] + done_n[1]) >= 12, 1'b1);
    auto_m[0] = 0; auto_m[1] = 0;
    for (int n = 0; n < 600 && (req_c[0] || req_c[1] || bus.arb_busy_o); n++) step();
    chk("rr_drained", {req_c[0], req_c[1], bus.arb_busy_o}, 3'b000);
    rnd_valid = 0; rnd_full = 0; full_c = 0;
    total = done_n[0] + done_n[1];
    chk("rr_grants", gq.size(), total);
    begin
      int order[$];
      for (int k = 0; k < total; k++) begin
        order.push_back(k % 2);
        if (k < gq.size()) chk($sformatf("rr_order%0d", k), gq[k], k % 2);
      end
      verify_stream("rr", order);
    end

    // Space gating with last=A
    clear_logs();
    new_frame(0, 2); run_until_done(0, 40); step(); step();
    space_c = W'(23);
    new_frame(1, 20); new_frame(0, 2);
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("sg_hold%0d", n), {bus.a_gnt_o, bus.b_gnt_o}, 2'b00);
    end
    space_c = W'(24);
    step();
    chk("sg_grant", {bus.a_gnt_o, bus.b_gnt_o}, 2'b01);
    run_until_done(1, 80);
    run_until_done(0, 40);
    step(); step();
    verify_stream("sg", '{0, 1, 0});
    space_c = W'(1000);

    // VALID and FULL stalls
    clear_logs();
    new_frame(0, 6);
    run_until_idx(0, 2, 40);
    ven[0] = 0;
    for (int n = 0; n < 4; n++) begin
      step();
      if (n > 0) chk($sformatf("st_vwe%0d", n), bus.buff_we_o, 1'b0);
    end
    ven[0] = 1;
    run_until_idx(0, 3, 20);
    full_c = 1;
    for (int n = 0; n < 2; n++) begin
      step();
      chk($sformatf("st_full%0d", n), {rdy_seen[0], bus.buff_we_o}, 2'b00);
    end
    full_c = 0;
    run_until_done(0, 40);
    step(); step();
    verify_stream("st", '{0});

    // LEN=1 frame
    clear_logs();
    new_frame(0, 1);
    run_until_done(0, 20);
    step(); step();
    verify_stream("l1", '{0});

    // LEN=0 request from A is never granted while B runs
    clear_logs();
    req_c[0] = 1; len_c[0] = '0; idx[0] = 0;
    new_frame(1, 2);
    a_seen = 0;
    for (int n = 0; n < 40 && done_n[1] == 0; n++) begin
      step(); a_seen |= bus.a_gnt_o;
    end
    for (int n = 0; n < 6; n++) begin
      step(); a_seen |= bus.a_gnt_o;
    end
    chk("l0_b_done", done_n[1], 1);
    chk("l0_no_a_gnt", a_seen, 1'b0);
    verify_stream("l0", '{1});
    req_c[0] = 0;
    step();

    // Reset mid-frame after 2 of 6 A words, then both request
    clear_logs();
    new_frame(0, 6);
    run_until_idx(0, 2, 40);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", all_outs(), 64'd0);
    @(negedge clk);
    clear_logs();
    new_frame(0, 6); new_frame(1, 3);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_first_gnt", {bus.a_gnt_o, bus.b_gnt_o}, 2'b10);
    run_until_done(0, 60);
    verify_stream("rst", '{0});
    run_until_done(1, 60);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/aq_gemac_tx_arb.md
# aq_gemac_tx_arb

Frame-level arbiter for the two-requester write side of the Gigabit MAC transmit buffer. Requester A is the host/DMA frame path and requester B is the on-chip ARP/ICMP responder. The block grants the buffer write port to one requester per frame, round-robin, and admits a frame only when the buffer has room for all of it. It then forwards the frame's 32-bit words as the buffer's WE/START/END/DATA sequence and, after END, waits out the buffer's checksum/finish sequence before granting again.

## Interface
- EMAC_TX_DEPTH, 10: log2 of buffer depth in words. Sets the width of LEN, SPACE and the word counter.
- MARGIN, 4: extra free words required beyond the frame length before a grant.

- BUFF_CLK  in  1  the single clock; all logic on its rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- A_REQ / B_REQ  in  1  a frame is pending. Held high with LEN stable until DONE.
- A_LEN / B_LEN  in  EMAC_TX_DEPTH  frame length in 32-bit words, including the first (header) word.
- A_VALID / B_VALID  in  1  A_DATA / B_DATA holds a valid word.
- A_DATA / B_DATA  in  32  frame word.
- A_READY / B_READY  out  1  the word is accepted at the edge where VALID&&READY.
- A_GNT / B_GNT  out  1  the frame is granted. High from grant until the last word is accepted.
- A_DONE / B_DONE  out  1  one-cycle pulse after the last word is accepted.
- BUFF_WE, BUFF_START, BUFF_END  out  1  buffer write strobe, first-word flag, last-word flag.
- BUFF_DATA  out  32  buffer write data.
- BUFF_READY  in  1  buffer idle, can start a frame.
- BUFF_FULL  in  1  buffer full.
- BUFF_SPACE  in  EMAC_TX_DEPTH  free words; reads 0 when full.
- ARB_BUSY  out  1  state is not S_IDLE.

## Operation
- States: S_IDLE, S_XFER, S_DONE. Registers: state, sel (owner), last (round-robin pointer), cnt (EMAC_TX_DEPTH bits), len latch.
- Eligibility: X is eligible when X_REQ=1 and X_LEN!=0.
  - A request with LEN=0 is treated as not requesting and is never granted.
- Round-robin choice in S_IDLE:
  - If both are eligible, choose the one that is not `last`.
  - Otherwise choose the single eligible requester.
- Admission, evaluated on the choice only:
  - Condition: BUFF_READY=1, BUFF_FULL=0, and {1'b0,BUFF_SPACE} >= {1'b0,X_LEN}+MARGIN, computed as an (EMAC_TX_DEPTH+1)-bit compare.
  - If it fails, stay in S_IDLE and re-evaluate every cycle.
  - No bypass to the other requester, so no starvation.
- Grant edge:
  - sel<=X, last<=X, len<=X_LEN, cnt<=0, X_GNT<=1, state<=S_XFER.
- S_XFER:
  - X_READY = X_GNT && state==S_XFER && !BUFF_FULL. This is combinational.
  - The non-selected READY is 0.
  - On each accept:
    - BUFF_WE<=1 and BUFF_DATA<=X_DATA.
    - BUFF_START<=(cnt==0).
    - BUFF_END<=(cnt==len-1).
    - cnt<=cnt+1.
  - When no word is accepted, BUFF_WE/START/END<=0 and BUFF_DATA holds its value.
  - VALID low mid-frame stalls with no timeout.
- Last accept (cnt==len-1):
  - X_GNT<=0, X_DONE<=1, state<=S_DONE, S_DONE counter<=0.
  - For len==1, START and END are asserted on the same word.
- S_DONE:
  - Lasts exactly 2 cycles, then goes to S_IDLE.
  - This lets the buffer's BUFF_READY fall and BUFF_SPACE update before the next admission.
  - The next grant additionally requires BUFF_READY=1 again.
- Requests dropping in S_XFER are ignored. The frame completes word-for-word per len.
- Reset, including mid-frame:
  - State S_IDLE; last=B, so A is served first.
  - cnt=0, len=0; all outputs 0, including BUFF_DATA=0.
  - A partially written frame is abandoned. The buffer is reset by the same RST_N.

## Timing
- Grant latency: X_GNT is high 1 cycle after the edge at which admission is true.
- Data latency: a word accepted at edge e appears on BUFF_WE/DATA for exactly the cycle after e.
- Throughput: one word per cycle when VALID stays high and FULL stays low.
- DONE pulses in the same cycle as BUFF_END. X_GNT is already low in that cycle.
- Earliest next grant: at the 3rd edge after the last accept, provided BUFF_READY=1.
- Minimum frame-to-frame gap on BUFF_WE: 3 idle cycles, more if the buffer's checksum sequence holds BUFF_READY low.
- BUFF_FULL rising mid-frame drops READY in the same cycle. No BUFF_WE is generated for the following cycle.

## Test plan
- Single A frame: A_LEN=5, SPACE=1000, VALID held high.
  - Required: GNT 1 cycle after REQ; 5 consecutive WE cycles; START on word 0 only; END and A_DONE on word 4; data order preserved; ARB_BUSY high from grant through S_DONE.
- Round-robin: A and B both requesting continuously, LEN=3 each, starting from reset.
  - Required: grant order A,B,A,B; ≥3-cycle WE gap between frames.
- Space gating: B_LEN=20, BUFF_SPACE=23.
  - Required: no grant. Raising SPACE to 24 grants on that edge.
  - A requesting meanwhile, with last=A: A is not granted.
- Stalls: VALID deasserted on word 2 for 4 cycles; BUFF_FULL pulsed 2 cycles on word 3.
  - Required: READY low during FULL; no WE during either stall; exactly LEN WE pulses total.
- Edge lengths: LEN=1 gives START=END=1 on one WE. LEN=0 is never granted while B (LEN=2) is served.
- Reset mid-frame: RST_N low after 2 of 6 words.
  - Required: all outputs 0 asynchronously; after release, A is granted first and cnt restarts at 0 with START on its first word.
